ct_tag_serializer: RTL
======================

Name: ct_tag_serializer

Overview:
- Downstream stage of the Triplex cipher core.
- Accepts each 128-bit ciphertext block on the core's ciphertext_valid/ciphertext_ready handshake, then the 128-bit tag when the core drops busy.
- Emits both as a W-bit word stream with valid/ready backpressure.
- Drives the core's ciphertext_ready, so the core stalls while the serializer is still draining.

Parameters:
- BLK_SIZE, 128, ciphertext/tag block width.
- W, 32, output word width; BLK_SIZE must be a multiple of W.
- NW, BLK_SIZE/W (localparam), words per block.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  same start pulse the core receives; arms a new message.
- ciphertext  in  BLK_SIZE  block from the core; valid only in the ciphertext_valid cycle.
- ciphertext_valid  in  1  one-cycle pulse from the core.
- ciphertext_last  in  1  last-block flag, shared with the core.
- ciphertext_ready  out  1  block buffer empty and armed.
- tag  in  BLK_SIZE  tag from the core; valid while busy=0 after FINAL.
- busy  in  1  core busy.
- dout  out  W  output word.
- dout_valid  out  1  word valid.
- dout_ready  in  1  consumer ready.
- dout_last  out  1  final tag word.
- dout_is_tag  out  1  current word belongs to the tag.
- overflow  out  1  sticky error flag.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE; buffer, word counter and last flag cleared.
- ciphertext_ready=0, dout_valid=0, dout_last=0, dout_is_tag=0, overflow=0, dout=0.

States: IDLE, WAIT_CT, SHIFT_CT, WAIT_TAG, SHIFT_TAG.

IDLE:
- On start: go to WAIT_CT and clear overflow.

WAIT_CT:
- ciphertext_ready=1, combinationally decoded from the registered state.
- On ciphertext_valid: capture ciphertext into the buffer, capture ciphertext_last into the last flag, set word counter=0, go to SHIFT_CT next cycle.

SHIFT_CT:
- dout = buffer[BLK_SIZE-1-W*cnt -: W], most-significant word first.
- dout_valid=1.
- A word transfers when dout_valid & dout_ready.
- On each transfer, cnt increments.
- On the transfer at cnt=NW-1: if the last flag is set go to WAIT_TAG, else go to WAIT_CT.
- dout must be held stable while dout_valid=1 and dout_ready=0.

WAIT_TAG:
- ciphertext_ready=0.
- When busy=0 is sampled: capture tag into the buffer, set cnt=0, go to SHIFT_TAG.
- busy=1 in this state is normal (the core is computing the tag); wait.

SHIFT_TAG:
- Same shifting as SHIFT_CT, with dout_is_tag=1.
- dout_last=1 when cnt=NW-1.
- On the final transfer go to IDLE.

Boundary conditions:
- ciphertext_valid in any state other than WAIT_CT: data dropped, overflow set to 1.
- overflow is cleared only by reset or start in IDLE.
- start outside IDLE is ignored.
- Latency: capture cycle, then first word valid in the next cycle. Minimum block-to-block spacing is NW+1 cycles with dout_ready held high.
- Counter width is clog2(NW). The counter wraps to 0 only on the state exit; it is never a free-running wrap.
- Simultaneous dout transfer on the final word and ciphertext_valid: the pulse counts as overflow, because ready was 0 in that cycle.
- Reset mid-stream: immediate return to IDLE, any partial block is discarded.

Decomposition:
- Shared package: state encoding constants, BLK_SIZE and W defaults, the NW function.
- One natural sub-module: block_shift_buf (BLK_SIZE-bit load register plus W-bit word mux plus counter, with load/advance/done). It is instantiated once and reused for both ciphertext and tag.
- The FSM lives in the top module.

Test Plan:
- Single-block message: start, then ciphertext=0x00112233_44556677_8899AABB_CCDDEEFF with last=1, then busy falls with tag=0xDEADBEEF_01234567_89ABCDEF_CAFEBABE.
  - dout sequence: 00112233, 44556677, 8899AABB, CCDDEEFF, DEADBEEF, 01234567, 89ABCDEF, CAFEBABE.
  - dout_is_tag=1 on the last 4 words; dout_last=1 only on CAFEBABE.
- Three-block message with dout_ready=1:
  - ciphertext_ready rises 5 cycles after each capture.
  - 12 ciphertext words, then 4 tag words.
- Backpressure: dout_ready low for 3 cycles at word 2.
  - dout holds 8899AABB with dout_valid=1 throughout.
  - ciphertext_ready stays 0 until the block drains.
- Overflow: ciphertext_valid pulse during SHIFT_CT.
  - overflow=1 and stays set; stream content unchanged.
  - The next start clears overflow.
- Reset mid-block: assert rst=0 at word 1.
  - All outputs 0 asynchronously, before the next clock edge.
  - After release, state IDLE and ciphertext_ready=0 until start.
- Tag wait: busy held 1 for 50 cycles after the last block.
  - dout_valid=0 for the whole wait.
  - Tag words appear starting 2 cycles after busy falls (capture cycle, then first word).

Source files
------------

// File: rtl/ct_tag_serializer_pkg.sv
// ct_tag_serializer shared package.
// State encoding, size defaults, word-count helpers.
package ct_tag_serializer_pkg;

  localparam int BLK_SIZE_DEF = 128;
  localparam int W_DEF        = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CT,
    S_SHIFT_CT,
    S_WAIT_TAG,
    S_SHIFT_TAG
  } state_t;

  function automatic int words_per_blk(
    input int blk,
    input int w
  );
    return blk / w;
  endfunction

  function automatic int cnt_width(
    input int nw
  );
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/ct_tag_serializer_block_shift_buf.sv
// Block buffer: BLK_SIZE load register, MSW-first word mux, counter.
// Ports: clk, rst(async low), load/load_data, advance -> word, done.
module ct_tag_serializer_block_shift_buf
  import ct_tag_serializer_pkg::*;
#(
  parameter int BLK_SIZE = BLK_SIZE_DEF,
  parameter int W        = W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [BLK_SIZE-1:0] load_data,
  input  logic                advance,
  output logic [W-1:0]        word,
  output logic                done
);

  localparam int NW = words_per_blk(BLK_SIZE, W);
  localparam int CW = cnt_width(NW);

  logic [NW-1:0][W-1:0] buf_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        idx;

  // Counter only wraps on the last word of a block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      buf_q <= load_data;
      cnt_q <= '0;
    end else if (advance) begin
      cnt_q <= done ? '0 : cnt_q + CW'(1);
    end
  end

  // Word NW-1 is the most significant slice
  assign idx  = CW'(NW - 1) - cnt_q;
  assign word = buf_q[idx];
  assign done = (cnt_q == CW'(NW - 1));

endmodule

// File: rtl/ct_tag_serializer.sv
// Serializes ciphertext blocks then the tag into a W-bit stream.
// Ports: start, ciphertext*, tag, busy in; dout* stream, overflow out.
module ct_tag_serializer
  import ct_tag_serializer_pkg::*;
#(
  parameter int BLK_SIZE = BLK_SIZE_DEF,
  parameter int W        = W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BLK_SIZE-1:0] ciphertext,
  input  logic                ciphertext_valid,
  input  logic                ciphertext_last,
  output logic                ciphertext_ready,
  input  logic [BLK_SIZE-1:0] tag,
  input  logic                busy,
  output logic [W-1:0]        dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                dout_is_tag,
  output logic                overflow
);

  state_t              state_q;
  logic                last_q;
  logic                overflow_q;

  logic                shifting;
  logic                xfer;
  logic                ct_load;
  logic                tag_load;
  logic                stray;
  logic                buf_load;
  logic [BLK_SIZE-1:0] buf_data;
  logic [W-1:0]        buf_word;
  logic                buf_done;

  assign shifting = (state_q == S_SHIFT_CT) ||
                    (state_q == S_SHIFT_TAG);
  assign xfer     = shifting & dout_ready;
  assign ct_load  = (state_q == S_WAIT_CT) & ciphertext_valid;
  assign tag_load = (state_q == S_WAIT_TAG) & ~busy;
  // Any pulse the buffer cannot take is lost
  assign stray    = ciphertext_valid & (state_q != S_WAIT_CT);
  assign buf_load = ct_load | tag_load;
  assign buf_data = tag_load ? tag : ciphertext;

  ct_tag_serializer_block_shift_buf #(
    .BLK_SIZE (BLK_SIZE),
    .W        (W)
  ) u_block_shift_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (buf_data),
    .advance   (xfer),
    .word      (buf_word),
    .done      (buf_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_WAIT_CT;
            overflow_q <= 1'b0;
          end
        end
        S_WAIT_CT: begin
          if (ciphertext_valid) begin
            last_q  <= ciphertext_last;
            state_q <= S_SHIFT_CT;
          end
        end
        S_SHIFT_CT: begin
          if (xfer && buf_done) begin
            state_q <= last_q ? S_WAIT_TAG
                              : S_WAIT_CT;
          end
        end
        S_WAIT_TAG: begin
          if (!busy) begin
            state_q <= S_SHIFT_TAG;
          end
        end
        S_SHIFT_TAG: begin
          if (xfer && buf_done) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A lost block outranks a same-cycle start clear
      if (stray) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign ciphertext_ready = (state_q == S_WAIT_CT);
  assign dout_valid       = shifting;
  assign dout_is_tag      = (state_q == S_SHIFT_TAG);
  assign dout_last        = dout_is_tag & buf_done;
  assign dout             = shifting ? buf_word : '0;
  assign overflow         = overflow_q;

endmodule
